srreg_rr_ctrl: RTL and testbench
================================

# srreg_rr_ctrl

Controller that shares one shift-right serializer register between two requesters. Each requester offers a parallel word with a valid/ready handshake. A round-robin arbiter grants one word at a time. The block loads the word into its internal shift-right register and shifts it out LSB-first, one bit per clock, then pulses `done` tagged with the owner's ID.

## Interface
- `WIDTH`, default 4: word width and number of bit-times per frame; legal range ≥ 2.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 offers `req0_data`.
- `req0_data` input WIDTH: requester 0 word.
- `req0_ready` output 1: requester 0 word accepted this cycle (handshake = valid & ready).
- `req1_valid` input 1: requester 1 offers `req1_data`.
- `req1_data` input WIDTH: requester 1 word.
- `req1_ready` output 1: requester 1 word accepted this cycle.
- `sout` output 1: serial bit, equal to `q[0]`.
- `sout_en` output 1: high exactly during the WIDTH bit-times of a frame.
- `busy` output 1: high in SHIFT and DONE states.
- `done` output 1: one-cycle pulse after the last bit.
- `done_id` output 1: owner of the frame just completed; valid while `done` is high, holds its value otherwise.
- `q` output WIDTH: shift register contents, for observability.

## Operation
- States:
  - IDLE → SHIFT on a handshake.
  - SHIFT → DONE when the bit counter is 0 at the clock edge.
  - DONE → IDLE unconditionally.
- Arbitration applies in IDLE only:
  - Only one valid: grant that requester.
  - Both valid: grant the requester not equal to `last_id`.
  - `last_id` resets to 1, so requester 0 wins the first contention.
  - `last_id` updates to the granted ID at each handshake.
- Ready signals:
  - `reqN_ready` is combinational: high only when state is IDLE, `rst` is low, `reqN_valid` is high, and N is the grant.
  - At most one ready is high in any cycle.
  - Both readys are 0 in SHIFT and DONE.
- Handshake edge:
  - `q` ← granted data.
  - `cnt` ← WIDTH-1, where `cnt` is ceil(log2(WIDTH)) bits.
  - `owner` ← granted ID.
  - state ← SHIFT.
- SHIFT, each edge:
  - `q` ← {1'b0, `q[WIDTH-1:1]`}, logical shift right with zero fill.
  - `cnt` decrements while nonzero.
  - At `cnt` == 0, state ← DONE.
- DONE: `done` = 1 and `done_id` = `owner`. `q` is 0 by this point.
- Data is sampled only at the handshake edge. A requester may drop valid before being granted; nothing is latched in that case. Requesters must hold data stable while valid is high and unaccepted.
- Reset values:
  - state IDLE, `q` = 0, `cnt` = 0, `owner` = 0, `last_id` = 1.
  - `done` = 0, `done_id` = 0, `busy` = 0, `sout_en` = 0, `sout` = 0.
  - `req0_ready` = `req1_ready` = 0 while `rst` is high.
- Reset mid-frame: the next cycle is in IDLE with all reset values. No `done` pulse for the aborted frame; the partial frame is discarded.
- Valid asserted during SHIFT/DONE: it waits, and is arbitrated in the next IDLE cycle.

## Timing
- Handshake at edge k (IDLE cycle k-1 shows ready high):
  - `sout` = data[0] during cycle k, through `sout` = data[WIDTH-1] during cycle k+WIDTH-1.
  - `sout_en` high for cycles k .. k+WIDTH-1.
  - `done` high in cycle k+WIDTH.
  - IDLE again in cycle k+WIDTH+1.
- Frame period under continuous demand: WIDTH+2 cycles (1 IDLE + WIDTH SHIFT + 1 DONE); 6 cycles at WIDTH=4.
- No new handshake in DONE; the earliest next grant is the following IDLE cycle.
- `busy` is registered and equal to (state != IDLE).

## Test plan
- **Reset:** hold `rst` high 2 cycles with both valids high → all outputs 0, both readys 0; after release, `req0_ready` = 1 first.
- **Single frame, WIDTH=4:** req0 only, data 4'b1011.
  - `req0_ready` high for 1 cycle.
  - `q` = 1011, 0101, 0010, 0001.
  - `sout` = 1, 1, 0, 1 with `sout_en` high for 4 cycles.
  - Then `done` = 1 with `done_id` = 0, then `busy` = 0.
- **Contention:** both valid from reset with req0 = 4'h9 and req1 = 4'h6.
  - req0 served first: `sout` 1, 0, 0, 1, `done_id` 0; `req1_ready` stays 0 throughout.
  - req1 granted in the next IDLE cycle: `sout` 0, 1, 1, 0, `done_id` 1.
- **Fairness:** both valids held high for 4 frames → grant order 0, 1, 0, 1; handshakes spaced exactly 6 cycles apart.
- **Reset mid-frame:** assert `rst` for 1 cycle after the 2nd bit of a req1 frame.
  - Next cycle: IDLE, `sout_en` 0, `q` 0, no `done`.
  - With both valid afterwards, req0 wins (`last_id` reset to 1).
- **Repeat requester:** req1 alone for 2 consecutive frames → req1 granted both times; second handshake 6 cycles after the first; `done_id` 1 both times.

Source files
------------

// File: rtl/srreg_rr_ctrl.sv
// srreg_rr_ctrl
// Shares one shift-right serializer between two requesters. A round-robin
// arbiter picks one offered word while idle, loads it into the shift
// register, shifts it out LSB-first one bit per clock, then pulses done
// tagged with the id of the requester that owned the frame.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   req0_valid   requester 0 offers req0_data
//   req0_data    requester 0 word (WIDTH bits)
//   req0_ready   requester 0 word accepted this cycle
//   req1_valid   requester 1 offers req1_data
//   req1_data    requester 1 word (WIDTH bits)
//   req1_ready   requester 1 word accepted this cycle
//   sout         serial bit, always q[0]
//   sout_en      high during the WIDTH bit-times of a frame
//   busy         high while a frame is shifting or completing
//   done         one-cycle pulse after the last bit
//   done_id      owner of the frame just completed, held between pulses
//   q            shift register contents

module srreg_rr_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] q
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_id;
  logic          grant;
  logic          idle;
  logic          handshake;

  // With both requesters valid, the one that was not served last wins;
  // otherwise whichever one is valid gets the grant.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_id;
    end
  end

  assign idle       = (state == ST_IDLE);
  assign req0_ready = idle && !rst && req0_valid && !grant;
  assign req1_ready = idle && !rst && req1_valid && grant;
  assign handshake  = req0_ready || req1_ready;

  assign sout    = q[0];
  assign sout_en = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

  // cnt is loaded with WIDTH-1 so that SHIFT lasts exactly WIDTH cycles;
  // the move to DONE happens on the edge where cnt is already zero.
  // busy is updated alongside state so it always mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      q       <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      last_id <= 1'b1;
      done_id <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            q       <= grant ? req1_data : req0_data;
            cnt     <= CW'(WIDTH - 1);
            owner   <= grant;
            last_id <= grant;
            state   <= ST_SHIFT;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          q <= {1'b0, q[WIDTH-1:1]};
          if (cnt == '0) begin
            state   <= ST_DONE;
            done_id <= owner;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srreg_rr_ctrl.sv
// tb_srreg_rr_ctrl
// Drives both requesters from a stimulus process that also predicts, from
// the arbitration rules and frame timing, which word is accepted in which
// cycle. Accepted words go into a scoreboard queue; a monitor process pops
// them when a frame appears on sout and checks bits, q, done and done_id.

module tb_srreg_rr_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         sout;
  logic         sout_en;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] q;

  srreg_rr_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sout       (sout),
    .sout_en    (sout_en),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .q          (q)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           hsCycle;
  } frame_t;

  frame_t expq[$];

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  // reference model of the controller, in terms of frames rather than states
  int busyLeft = 0;
  bit lastId   = 1'b1;
  bit acc0;
  bit acc1;
  bit lastHsId;
  int lastHsCycle;
  int monBitIdx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict the readys,
  // and record an expected frame whenever a word is accepted.
  task automatic applyStimulus(input logic r, input logic v0, input logic [W-1:0] d0,
                               input logic v1, input logic [W-1:0] d1);
    logic e0;
    logic e1;
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (r) begin
      busyLeft = 0;
      lastId   = 1'b1;
      expq.delete();
    end else if (busyLeft > 0) begin
      busyLeft--;
    end else if (v0 && v1) begin
      if (lastId) e0 = 1'b1;
      else        e1 = 1'b1;
    end else begin
      e0 = v0;
      e1 = v1;
    end
    checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
    acc0 = e0;
    acc1 = e1;
    if (e0 || e1) begin
      expq.push_back('{id: e1, data: (e1 ? d1 : d0), hsCycle: cycle});
      lastId      = e1;
      lastHsId    = e1;
      lastHsCycle = cycle;
      busyLeft    = W + 1;
    end
  endtask

  // Monitor: frames are consumed from the scoreboard as they appear on sout.
  initial begin
    frame_t cur;
    bit     lastDoneId;
    cur        = '{id: 1'b0, data: '0, hsCycle: 0};
    lastDoneId = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        checkOutput("rst q", 32'(q), 32'd0);
        checkOutput("rst sout_en", 32'(sout_en), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done_id", 32'(done_id), 32'd0);
        checkOutput("rst sout", 32'(sout), 32'd0);
        monBitIdx  = 0;
        lastDoneId = 1'b0;
      end else if (sout_en) begin
        if (monBitIdx == 0) begin
          checkOutput("frame expected", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) cur = expq.pop_front();
          checkOutput("frame start cycle", 32'(cycle), 32'(cur.hsCycle + 1));
        end
        if (monBitIdx >= W) begin
          checkOutput("frame length", 32'(monBitIdx), 32'(W - 1));
        end else begin
          checkOutput("sout bit", 32'(sout), 32'(cur.data[monBitIdx]));
          checkOutput("q shift", 32'(q), 32'(cur.data >> monBitIdx));
          monBitIdx++;
        end
        checkOutput("done in shift", 32'(done), 32'd0);
        checkOutput("busy in shift", 32'(busy), 32'd1);
      end else if (done) begin
        checkOutput("bits before done", 32'(monBitIdx), 32'(W));
        checkOutput("done_id", 32'(done_id), 32'(cur.id));
        checkOutput("busy in done", 32'(busy), 32'd1);
        checkOutput("q at done", 32'(q), 32'd0);
        lastDoneId = cur.id;
        monBitIdx  = 0;
      end else begin
        checkOutput("done after last bit", 32'(monBitIdx), 32'd0);
        monBitIdx = 0;
        checkOutput("busy idle", 32'(busy), 32'd0);
        checkOutput("done_id hold", 32'(done_id), 32'(lastDoneId));
        checkOutput("q idle", 32'(q), 32'd0);
      end
    end
  end

  initial begin
    bit           p0;
    bit           p1;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    int           hsCnt;
    int           hsCyc[$];
    bit           hsId[$];
    bit           firstId;
    bit           gotFirst;

    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;

    $display("[TB] reset with both requesters valid");
    applyStimulus(1'b1, 1'b1, 4'h9, 1'b1, 4'h6);
    applyStimulus(1'b1, 1'b1, 4'h9, 1'b1, 4'h6);

    $display("[TB] contention after reset");
    p0 = 1'b1;
    p1 = 1'b1;
    gotFirst = 1'b0;
    firstId  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, p0, 4'h9, p1, 4'h6);
      if ((acc0 || acc1) && !gotFirst) begin
        gotFirst = 1'b1;
        firstId  = acc1;
      end
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end
    checkOutput("contention first grant", 32'(firstId), 32'd0);
    checkOutput("contention both served", 32'(p0 || p1), 32'd0);

    $display("[TB] single frame from requester 0");
    p0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, p0, 4'b1011, 1'b0, 4'h0);
      if (acc0) p0 = 1'b0;
    end
    checkOutput("single frame served", 32'(p0), 32'd0);

    $display("[TB] fairness with continuous demand");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    rd0   = W'($urandom);
    rd1   = W'($urandom);
    hsCnt = 0;
    for (int i = 0; i < 60 && hsCnt < 4; i++) begin
      applyStimulus(1'b0, 1'b1, rd0, 1'b1, rd1);
      if (acc0 || acc1) begin
        hsCnt++;
        hsCyc.push_back(lastHsCycle);
        hsId.push_back(lastHsId);
      end
      if (acc0) rd0 = W'($urandom);
      if (acc1) rd1 = W'($urandom);
    end
    checkOutput("fairness handshakes", 32'(hsCnt), 32'd4);
    for (int i = 0; i < hsId.size(); i++) begin
      checkOutput("fairness order", 32'(hsId[i]), 32'(i % 2));
      if (i > 0) checkOutput("fairness spacing", 32'(hsCyc[i] - hsCyc[i-1]), 32'(W + 2));
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    $display("[TB] reset in the middle of a requester 1 frame");
    p1 = 1'b1;
    for (int i = 0; i < 5 && p1; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'hA);
      if (acc1) p1 = 1'b0;
    end
    checkOutput("mid-frame grant", 32'(p1), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    p0 = 1'b1;
    p1 = 1'b1;
    gotFirst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, p0, 4'h5, p1, 4'hC);
      if ((acc0 || acc1) && !gotFirst) begin
        gotFirst = 1'b1;
        firstId  = acc1;
      end
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end
    checkOutput("post-reset first grant", 32'(firstId), 32'd0);

    $display("[TB] requester 1 alone for two frames");
    hsCyc.delete();
    hsId.delete();
    rd1 = 4'h3;
    for (int i = 0; i < 20 && hsCyc.size() < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, rd1);
      if (acc1) begin
        hsCyc.push_back(lastHsCycle);
        hsId.push_back(lastHsId);
        rd1 = 4'hE;
      end
    end
    checkOutput("repeat handshakes", 32'(hsCyc.size()), 32'd2);
    if (hsCyc.size() == 2) begin
      checkOutput("repeat spacing", 32'(hsCyc[1] - hsCyc[0]), 32'(W + 2));
      checkOutput("repeat id", 32'(hsId[1]), 32'd1);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    $display("[TB] randomized traffic");
    p0  = 1'b0;
    p1  = 1'b0;
    rd0 = '0;
    rd1 = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1'b1, p0, rd0, p1, rd1);
        acc0 = 1'b0;
        acc1 = 1'b0;
      end else begin
        applyStimulus(1'b0, p0, rd0, p1, rd1);
      end
      if (acc0 || !p0) begin
        p0  = 1'($urandom_range(0, 1));
        rd0 = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        p0 = 1'b0;
      end
      if (acc1 || !p1) begin
        p1  = 1'($urandom_range(0, 1));
        rd1 = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        p1 = 1'b0;
      end
    end

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("scoreboard drained", 32'(expq.size()), 32'd0);
    checkOutput("no frame in flight", 32'(monBitIdx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
